ua_route_sequencer: RTL and testbench
=====================================

Name: ua_route_sequencer

Overview:
- Digital controller for the analog-pin routing switches that tie internal supplies and references (VGND, VDPWR, VAPWR, external) onto a shared ua pad.
- Arbitrates route requests from two requesters, e.g. a ui_in-driven manual selector and a test/calibration sequencer.
- Enforces break-before-make sequencing with a programmable dead time and a settling time, so two sources are never shorted together.
- Reports the active route and a settled flag; these are mirrored on uo_out.

Parameters:
- NSRC, 4: number of switchable sources. One-hot switch enable per source.
- SELW, 3: width of the route code. Must satisfy 2^SELW > NSRC.
- DEAD_CYC, 2: break-before-make dead time in clk cycles. Must be ≥1.
- SETTLE_CYC, 4: settling wait after make, in clk cycles. Must be ≥1.
- CNTW, 8: width of the internal timer. Must hold max(DEAD_CYC, SETTLE_CYC).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  2  per-requester request valid.
- req_code  in  2*SELW  per-requester route code; requester i uses bits [i*SELW +: SELW].
- req_ready  out  2  per-requester accept. Combinational; a transfer occurs when valid&ready are both high at a clock edge.
- sw_en  out  NSRC  analog switch enables. Always one-hot or zero.
- cur_code  out  SELW  code of the committed route.
- busy  out  1  sequencing is in progress.
- settled  out  1  route is stable and settled.
- err  out  1  one-cycle pulse when an illegal code is accepted.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: sw_en=0, cur_code=0, busy=0, settled=0, err=0, req_ready=0, timer=0, state=IDLE. Round-robin priority points to requester 0.
- Code meaning:
  - 0 = disconnect, all switches open.
  - k in 1..NSRC = close switch k-1.
  - k > NSRC = illegal.
- States: IDLE, BREAK, MAKE.
- IDLE:
  - req_ready is asserted only in IDLE, and only to the single requester granted this cycle.
  - If both requesters are valid, the priority holder wins. After any accept, priority moves to the other requester.
  - If only one requester is valid, it is granted regardless of priority.
  - Accept cycle is T.
- Illegal code accepted at T: err=1 at T+1 for one cycle. sw_en, cur_code and settled are unchanged. State stays IDLE.
- Code equal to cur_code accepted while settled=1: no sequencing, all outputs unchanged, and a new request may be accepted at T+1.
- Any other legal code accepted at T:
  - T+1: state=BREAK, sw_en=0, busy=1, settled=0, cur_code=new code.
  - BREAK lasts DEAD_CYC cycles, T+1 .. T+DEAD_CYC.
  - If the code is 0: at T+DEAD_CYC+1, state=IDLE, busy=0, settled=1, sw_en=0.
  - Otherwise: at T+DEAD_CYC+1, state=MAKE and sw_en=onehot(code-1). MAKE lasts SETTLE_CYC cycles. At T+DEAD_CYC+SETTLE_CYC+1, state=IDLE, busy=0, settled=1.
- Requests during BREAK/MAKE: req_ready=0. Requesters must hold req_valid and req_code stable until accepted. Sequencing cannot be aborted.
- Re-accept: the earliest next accept is the cycle in which IDLE is re-entered, i.e. when busy is low.
- Timer: loads the phase length on phase entry and decrements to 1. There is no wrap-around, and the timer is never used in IDLE.
- Invariants:
  - sw_en never changes directly from one nonzero value to a different nonzero value.
  - Any change of sw_en is preceded by at least DEAD_CYC cycles of zero.
  - busy and settled are never both 1.
- rst asserted mid-sequence: the next edge forces all reset values, including sw_en=0. Switches open immediately; no dead-time wait applies.
- req_valid asserted during rst: ignored, and req_ready=0.

Test Plan (NSRC=4, DEAD_CYC=2, SETTLE_CYC=4):
- Reset, then requester 0 sends code 3 → accept at T; sw_en=0 at T+1..T+2; sw_en=4'b0100 from T+3; settled=1 and busy=0 at T+7; cur_code=3.
- From code 3 settled, requester 1 sends code 1 → sw_en=0 for exactly 2 cycles, then 4'b0001. Never 4'b0101 at any cycle.
- Both requesters valid in IDLE with codes 2 and 4 (priority at 0) → requester 0 is granted first; requester 1 is granted when IDLE returns. Final sw_en=4'b1000. Repeat with priority at 1 → grant order is reversed.
- Code 7 accepted → err=1 for exactly one cycle; sw_en, cur_code and settled unchanged. Code 0 from an active route → sw_en=0 from T+1; settled=1 at T+3.
- Same code as current while settled → req_ready pulses; no busy, sw_en glitch-free; err=0.
- rst pulsed at MAKE cycle 2 → at the next edge sw_en=0, cur_code=0, settled=0, busy=0; a new request is accepted the cycle after rst deasserts.

Source files
------------

// File: rtl/ua_route_sequencer.sv
// Break-before-make sequencer for the ua pad routing switches.
// Two requesters are round-robin arbitrated. An accepted route change opens
// every switch for DEAD_CYC cycles, then closes the new switch and waits
// SETTLE_CYC cycles before reporting the route as settled.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | route stable (or disconnected); requests may be accepted
// BREAK   | all switches open; dead time running
// MAKE    | new switch closed; settling time running
module ua_route_sequencer #(
    parameter int NSRC       = 4,
    parameter int SELW       = 3,
    parameter int DEAD_CYC   = 2,
    parameter int SETTLE_CYC = 4,
    parameter int CNTW       = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_valid_i,
    input  logic [2*SELW-1:0]   req_code_i,
    output logic [1:0]          req_ready_o,
    output logic [NSRC-1:0]     sw_en_o,
    output logic [SELW-1:0]     cur_code_o,
    output logic                busy_o,
    output logic                settled_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   timer_q, timer_d;
    logic [NSRC-1:0]   sw_en_q, sw_en_d;
    logic [SELW-1:0]   cur_code_q, cur_code_d;
    logic              settled_q, settled_d;
    logic              err_q, err_d;
    logic              rr_q, rr_d;

    logic [1:0]        gnt;
    logic              accept;
    logic [SELW-1:0]   acc_code;
    logic              code_illegal;
    logic              code_same;
    logic              start_seq;
    logic              timer_last;

    // Decode a route code to its switch; code 0 (and illegal codes) map to all-open.
    function automatic logic [NSRC-1:0] code_to_sw(input logic [SELW-1:0] code);
        logic [NSRC-1:0] sw;
        sw = '0;
        for (int i = 0; i < NSRC; i++) begin
            sw[i] = (code == SELW'(i + 1));
        end
        return sw;
    endfunction

    // Round-robin grant; only offered in IDLE and never while reset is asserted.
    always_comb begin
        gnt          = 2'b00;
        if ((state_q == ST_IDLE) && !rst_i) begin
            gnt[0] = req_valid_i[0] & (~req_valid_i[1] | ~rr_q);
            gnt[1] = req_valid_i[1] & (~req_valid_i[0] |  rr_q);
        end
        accept       = |gnt;
        acc_code     = gnt[1] ? req_code_i[SELW +: SELW] : req_code_i[0 +: SELW];
        code_illegal = (acc_code > SELW'(NSRC));
        code_same    = (acc_code == cur_code_q) && settled_q;
        start_seq    = accept && !code_illegal && !code_same;
        timer_last   = (timer_q == CNTW'(1));
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            sw_en_q    <= '0;
            cur_code_q <= '0;
            settled_q  <= 1'b0;
            err_q      <= 1'b0;
            rr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sw_en_q    <= sw_en_d;
            cur_code_q <= cur_code_d;
            settled_q  <= settled_d;
            err_q      <= err_d;
            rr_q       <= rr_d;
        end
    end

    // Next-state and phase timer: timer loads the phase length on entry and counts down to 1.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (start_seq) begin
                    state_d = ST_BREAK;
                    timer_d = CNTW'(DEAD_CYC);
                end
            end
            ST_BREAK: begin
                if (timer_last) begin
                    if (cur_code_q == '0) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else begin
                        state_d = ST_MAKE;
                        timer_d = CNTW'(SETTLE_CYC);
                    end
                end else begin
                    timer_d = timer_q - CNTW'(1);
                end
            end
            ST_MAKE: begin
                if (timer_last) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Output and route bookkeeping: switches only close at the BREAK->MAKE boundary.
    always_comb begin
        sw_en_d    = sw_en_q;
        cur_code_d = cur_code_q;
        settled_d  = settled_q;
        err_d      = 1'b0;
        rr_d       = rr_q;
        if (accept) begin
            rr_d  = gnt[0];
            err_d = code_illegal;
        end
        if (start_seq) begin
            sw_en_d    = '0;
            settled_d  = 1'b0;
            cur_code_d = acc_code;
        end
        if ((state_q == ST_BREAK) && timer_last) begin
            if (cur_code_q == '0) begin
                settled_d = 1'b1;
            end else begin
                sw_en_d = code_to_sw(cur_code_q);
            end
        end
        if ((state_q == ST_MAKE) && timer_last) begin
            settled_d = 1'b1;
        end
        req_ready_o = gnt;
        sw_en_o     = sw_en_q;
        cur_code_o  = cur_code_q;
        busy_o      = (state_q != ST_IDLE);
        settled_o   = settled_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_ua_route_sequencer.sv
// Bench for ua_route_sequencer: directed scenarios followed by random traffic,
// all checked every cycle against a timeline model of the route sequencing.
module tb_ua_route_sequencer;

    localparam int NSRC   = 4;
    localparam int SELW   = 3;
    localparam int DEAD   = 2;
    localparam int SETTLE = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        vld;
    logic [2*SELW-1:0] code_bus;
    logic [1:0]        rdy;
    logic [NSRC-1:0]   sw_en;
    logic [SELW-1:0]   cur_code;
    logic              busy;
    logic              settled;
    logic              err;

    int rc [2];

    assign code_bus = {rc[1][SELW-1:0], rc[0][SELW-1:0]};

    ua_route_sequencer #(
        .NSRC(NSRC), .SELW(SELW), .DEAD_CYC(DEAD), .SETTLE_CYC(SETTLE), .CNTW(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(vld), .req_code_i(code_bus),
        .req_ready_o(rdy), .sw_en_o(sw_en), .cur_code_o(cur_code),
        .busy_o(busy), .settled_o(settled), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: route history expressed as accept time plus elapsed cycles.
    bit m_seq      = 0;
    int m_t0       = 0;
    int m_code     = 0;
    int m_cur      = 0;
    bit m_settled  = 0;
    int m_err_cyc  = -100;
    bit m_rr       = 0;

    logic [NSRC-1:0] prev_sw  = '0;
    int              zero_run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NSRC-1:0] oh(input int c);
        logic [NSRC-1:0] r;
        r = '0;
        if (c >= 1 && c <= NSRC) r[c-1] = 1'b1;
        return r;
    endfunction

    // One clock cycle: compare DUT with the model, advance the model, clock, drop granted requests.
    task automatic step();
        int d;
        int w;
        int acode;
        logic [NSRC-1:0] e_sw;
        logic e_busy, e_set, e_err;
        logic [1:0] e_rdy;
        w = -1;
        #1;
        e_busy = 1'b0;
        e_set  = m_settled;
        e_sw   = oh(m_cur);
        if (m_seq) begin
            d = cyc - m_t0;
            if (d <= DEAD) begin
                e_sw = '0; e_busy = 1'b1; e_set = 1'b0;
            end else if (m_code != 0 && d <= DEAD + SETTLE) begin
                e_busy = 1'b1; e_set = 1'b0;
            end else begin
                m_seq = 0; m_settled = 1; e_set = 1'b1;
            end
        end
        e_err = (m_err_cyc == cyc - 1);
        e_rdy = 2'b00;
        if (!rst && !e_busy) begin
            if (vld[0] && (!vld[1] || !m_rr)) e_rdy = 2'b01;
            else if (vld[1])                  e_rdy = 2'b10;
        end
        chk("req_ready", 32'(rdy), 32'(e_rdy));
        chk("sw_en", 32'(sw_en), 32'(e_sw));
        chk("cur_code", 32'(cur_code), 32'(m_cur));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("settled", 32'(settled), 32'(e_set));
        chk("err", 32'(err), 32'(e_err));
        chk("sw_onehot0", 32'($onehot0(sw_en)), 32'(1));
        chk("busy_and_settled", 32'(busy & settled), 32'(0));
        if (sw_en != prev_sw && sw_en != '0)
            chk("break_before_make", 32'(prev_sw == '0 && zero_run >= DEAD), 32'(1));
        zero_run = (sw_en == '0) ? zero_run + 1 : 0;
        prev_sw  = sw_en;

        if (rst) begin
            m_seq = 0; m_cur = 0; m_settled = 0; m_rr = 0; m_err_cyc = -100;
        end else if (e_rdy != 2'b00) begin
            w     = e_rdy[1] ? 1 : 0;
            acode = rc[w];
            m_rr  = (w == 0);
            if (acode > NSRC) begin
                m_err_cyc = cyc;
            end else if (!(acode == m_cur && m_settled)) begin
                m_seq = 1; m_t0 = cyc; m_code = acode; m_cur = acode; m_settled = 0;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (w >= 0) vld[w] = 1'b0;
    endtask

    task automatic req(input int w, input int c);
        vld[w] = 1'b1;
        rc[w]  = c;
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((vld != 2'b00 || m_seq) && n < 200);
        if (vld != 2'b00 || m_seq) chk("timeout", 32'(vld), 32'(0));
    endtask

    initial begin
        rst = 1'b1; vld = 2'b00; rc[0] = 0; rc[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Requests during reset are ignored.
        req(0, 3); req(1, 2);
        step();
        rst = 1'b0; vld = 2'b00;
        step();

        // Single requester route, then a route change.
        req(0, 3); run_until_idle();
        req(1, 1); run_until_idle();
        // Both valid, priority at 0.
        req(0, 2); req(1, 4); run_until_idle();
        // Move priority to requester 1, then both valid again.
        req(0, 1); run_until_idle();
        req(0, 2); req(1, 4); run_until_idle();
        // Illegal code, disconnect, same code while settled.
        req(1, 7); run_until_idle(); step();
        req(0, 0); run_until_idle();
        req(1, 0); run_until_idle(); step();
        req(0, 4); run_until_idle();
        req(1, 4); run_until_idle(); step();
        // Reset during MAKE cycle 2.
        req(0, 2);
        while (vld[0]) step();
        repeat (DEAD + 1) step();
        rst = 1'b1; step(); rst = 1'b0;
        req(1, 3); run_until_idle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int w = 0; w < 2; w++) begin
                if (!vld[w] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 9) < 8) req(w, int'($urandom_range(0, NSRC)));
                    else                          req(w, int'($urandom_range(NSRC + 1, 7)));
                end
            end
            step();
        end
        rst = 1'b0;
        vld = 2'b00;
        run_until_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
